// File: rtl/ibus_dbus_arbiter.sv
// Two-port (fetch/data) to single downstream bus arbiter with one transaction
// in flight, fetch starvation protection and combinational handshake pass-through.
`timescale 1ns/1ps
module ibus_dbus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter bit          DATA_PRIO    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_addr_ok,
  input  logic        mresp_data_ok,
  input  logic [63:0] mresp_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [3:0]  starve_q, starve_d;
  logic        fetch_wins;
  logic        fetch_txn;
  logic        addr_ok;
  logic        data_ok;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    starve_d   = starve_q;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    fetch_wins = ireq_valid && (!dreq_valid || (starve_q == LIMIT) || !DATA_PRIO);

    case (state_q)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          if (fetch_wins) begin
            state_d  = I_ADDR;
            addr_d   = ireq_addr;
            size_d   = 3'd2;
            strobe_d = '0;
            data_d   = '0;
            starve_d = '0;
          end else begin
            state_d  = D_ADDR;
            addr_d   = dreq_addr;
            size_d   = dreq_size;
            strobe_d = dreq_strobe;
            data_d   = dreq_data;
            // only a lost tie counts; a lone data request leaves the count alone
            if (ireq_valid && (starve_q < LIMIT)) starve_d = starve_q + 4'd1;
          end
        end
      end
      I_ADDR, D_ADDR: begin
        addr_ok = mresp_addr_ok;
        data_ok = mresp_addr_ok && mresp_data_ok;
        if (data_ok)      state_d = IDLE;
        else if (addr_ok) state_d = (state_q == I_ADDR) ? I_DATA : D_DATA;
      end
      I_DATA, D_DATA: begin
        data_ok = mresp_data_ok;
        if (data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    fetch_txn     = (state_q inside {I_ADDR, I_DATA});
    mreq_valid    = (state_q inside {I_ADDR, D_ADDR});
    mreq_addr     = addr_q;
    mreq_size     = size_q;
    mreq_strobe   = strobe_q;
    mreq_data     = data_q;
    iresp_addr_ok = fetch_txn && addr_ok;
    iresp_data_ok = fetch_txn && data_ok;
    dresp_addr_ok = !fetch_txn && addr_ok;
    dresp_data_ok = !fetch_txn && data_ok;
    // data paths are gated so nothing leaks out while reset is held
    iresp_data    = !reset ? '0 : (addr_q[2] ? mresp_data[63:32] : mresp_data[31:0]);
    dresp_data    = !reset ? '0 : mresp_data;
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Self-checking bench for ibus_dbus_arbiter: directed vector table, hand-written
// starvation/reset sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_ibus_dbus_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam bit          DPRIO = 1'b1;
  localparam logic [63:0] IADDR = 64'h0000_0000_8000_0004;
  localparam logic [63:0] DADDR = 64'h0000_0000_1000_0010;
  localparam logic [63:0] DDATA = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] MDATA = 64'h1111_2222_3333_4444;

  logic        clk, reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_addr_ok, mresp_data_ok;
  logic [63:0] mresp_data;

  ibus_dbus_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_PRIO(DPRIO)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv, dv;
    logic [7:0] dstrb;
    logic       maok, mdok;
    logic       emv;
    logic [2:0] esize;
    logic [7:0] estrb;
    logic       eia, eid, eda, edd;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic dv, input logic [7:0] dstrb,
                              input logic maok, input logic mdok, input logic emv,
                              input logic [2:0] esize, input logic [7:0] estrb,
                              input logic eia, input logic eid, input logic eda, input logic edd);
    vec_t v;
    v.iv = iv; v.dv = dv; v.dstrb = dstrb; v.maok = maok; v.mdok = mdok;
    v.emv = emv; v.esize = esize; v.estrb = estrb;
    v.eia = eia; v.eid = eid; v.eda = eda; v.edd = edd;
    return v;
  endfunction

  vec_t tbl[$];

  // transaction-level reference: who owns the bus and whether its address is accepted
  int          owner;      // 0 none, 1 fetch, 2 data
  bit          addr_done;
  int          starve;
  logic [63:0] m_addr, m_data;
  logic [2:0]  m_size;
  logic [7:0]  m_strb;

  task automatic clear_inputs();
    ireq_valid = 0; dreq_valid = 0; mresp_addr_ok = 0; mresp_data_ok = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   fwin, exp_mv, exp_aok, exp_dok;
    byte  seen[$];
    reset = 0;
    clear_inputs();
    ireq_addr = IADDR; dreq_addr = DADDR; dreq_size = 3'd3; dreq_strobe = 8'hFF;
    dreq_data = DDATA; mresp_data = MDATA;

    #1;
    chk("rst_mreq_valid", mreq_valid, 0);
    chk("rst_oks", {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 0);
    chk("rst_iresp_data", iresp_data, 0);
    chk("rst_dresp_data", dresp_data, 0);
    chk("rst_mreq_addr", mreq_addr, 0);
    @(negedge clk); reset = 1;

    // iv dv dstrb maok mdok | emv esize estrb ia id da dd
    tbl.push_back(mk(1,0,8'hFF,0,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(1,0,8'hFF,0,0, 1,3'd2,8'h00, 0,0,0,0));
    tbl.push_back(mk(1,0,8'hFF,1,0, 1,3'd2,8'h00, 1,0,0,0));
    tbl.push_back(mk(0,0,8'hFF,0,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(0,0,8'hFF,0,1, 0,3'd0,8'h00, 0,1,0,0));
    tbl.push_back(mk(0,0,8'hFF,0,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(1,1,8'hFF,0,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(1,1,8'hFF,0,1, 1,3'd3,8'hFF, 0,0,0,0));
    tbl.push_back(mk(1,1,8'hFF,1,0, 1,3'd3,8'hFF, 0,0,1,0));
    tbl.push_back(mk(1,0,8'hFF,1,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(1,0,8'hFF,0,1, 0,3'd0,8'h00, 0,0,0,1));
    tbl.push_back(mk(1,0,8'hFF,0,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(1,0,8'hFF,1,1, 1,3'd2,8'h00, 1,1,0,0));
    tbl.push_back(mk(0,0,8'hFF,1,1, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(0,1,8'h00,0,0, 0,3'd0,8'h00, 0,0,0,0));
    tbl.push_back(mk(0,0,8'hFF,1,1, 1,3'd3,8'h00, 0,0,1,1));
    tbl.push_back(mk(0,0,8'hFF,0,0, 0,3'd0,8'h00, 0,0,0,0));

    foreach (tbl[k]) begin
      @(negedge clk);
      ireq_valid = tbl[k].iv; dreq_valid = tbl[k].dv; dreq_strobe = tbl[k].dstrb;
      mresp_addr_ok = tbl[k].maok; mresp_data_ok = tbl[k].mdok;
      #1;
      chk($sformatf("vec%0d_mreq_valid", k), mreq_valid, tbl[k].emv);
      chk($sformatf("vec%0d_iresp_addr_ok", k), iresp_addr_ok, tbl[k].eia);
      chk($sformatf("vec%0d_iresp_data_ok", k), iresp_data_ok, tbl[k].eid);
      chk($sformatf("vec%0d_dresp_addr_ok", k), dresp_addr_ok, tbl[k].eda);
      chk($sformatf("vec%0d_dresp_data_ok", k), dresp_data_ok, tbl[k].edd);
      if (tbl[k].emv) begin
        chk($sformatf("vec%0d_mreq_size", k), mreq_size, tbl[k].esize);
        chk($sformatf("vec%0d_mreq_strobe", k), mreq_strobe, tbl[k].estrb);
        chk($sformatf("vec%0d_mreq_addr", k), mreq_addr, (tbl[k].esize == 3'd2) ? IADDR : DADDR);
        chk($sformatf("vec%0d_mreq_data", k), mreq_data, (tbl[k].esize == 3'd2) ? 64'h0 : DDATA);
      end
      if (tbl[k].eid) chk($sformatf("vec%0d_iresp_data", k), iresp_data, 64'h1111_2222);
      if (tbl[k].edd) chk($sformatf("vec%0d_dresp_data", k), dresp_data, MDATA);
    end

    // continuous contention: expect D,D,D,D,I repeating
    @(negedge clk);
    ireq_valid = 1; dreq_valid = 1; mresp_addr_ok = 1; mresp_data_ok = 1;
    for (int cyc = 0; cyc < 40 && seen.size() < 10; cyc++) begin
      #1;
      if (iresp_addr_ok) seen.push_back("I");
      if (dresp_addr_ok) seen.push_back("D");
      @(negedge clk);
    end
    clear_inputs();
    if (seen.size() < 10) begin
      checks++; failures++;
      $display("FAIL starve_pattern_timeout actual=%0d grants expected=10", seen.size());
    end
    for (int n = 0; n < seen.size() && n < 10; n++)
      chk($sformatf("starve_grant%0d", n), seen[n], (n % 5 == 4) ? "I" : "D");

    // reset during D_DATA with a stale data_ok afterwards
    @(negedge clk);
    ireq_valid = 1; dreq_valid = 1;
    @(negedge clk);
    ireq_valid = 0; dreq_valid = 0; mresp_addr_ok = 1;
    #1 chk("rstmid_dresp_addr_ok", dresp_addr_ok, 1);
    chk("rstmid_starve_before", dut.starve_q, 1);
    @(negedge clk);
    mresp_addr_ok = 0;
    #1 chk("rstmid_in_ddata_mreq_valid", mreq_valid, 0);
    #1 reset = 0; mresp_data_ok = 1;
    #1;
    chk("rstmid_dresp_data_ok", dresp_data_ok, 0);
    chk("rstmid_mreq_valid", mreq_valid, 0);
    chk("rstmid_starve", dut.starve_q, 0);
    chk("rstmid_iresp_data", iresp_data, 0);
    chk("rstmid_dresp_data", dresp_data, 0);
    repeat (3) @(negedge clk);
    reset = 1; dreq_valid = 1; mresp_data_ok = 1;
    #1;
    chk("rel_dresp_data_ok", dresp_data_ok, 0);
    chk("rel_mreq_valid", mreq_valid, 0);
    chk("rel_starve", dut.starve_q, 0);
    @(negedge clk);
    dreq_valid = 0; mresp_addr_ok = 1; mresp_data_ok = 1;
    #1;
    chk("rel_first_arb_mreq_valid", mreq_valid, 1);
    chk("rel_first_arb_oks", {dresp_addr_ok, dresp_data_ok}, 2'b11);
    @(negedge clk);
    clear_inputs();

    // randomized run against the transaction model
    reset = 0;
    @(negedge clk);
    reset = 1;
    owner = 0; addr_done = 0; starve = 0;
    m_addr = '0; m_data = '0; m_size = '0; m_strb = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ireq_valid    = ($urandom_range(3) != 0);
      dreq_valid    = ($urandom_range(3) != 0);
      ireq_addr     = {$urandom(), $urandom()} & ~64'h3;
      dreq_addr     = {$urandom(), $urandom()};
      dreq_size     = 3'($urandom_range(3));
      dreq_strobe   = 8'($urandom());
      dreq_data     = {$urandom(), $urandom()};
      mresp_addr_ok = $urandom_range(1) == 1;
      mresp_data_ok = $urandom_range(2) == 0;
      mresp_data    = {$urandom(), $urandom()};
      #1;
      exp_mv  = (owner != 0) && !addr_done;
      exp_aok = exp_mv && mresp_addr_ok;
      exp_dok = (owner != 0) && (addr_done ? mresp_data_ok : (mresp_addr_ok && mresp_data_ok));
      chk("rnd_mreq_valid", mreq_valid, exp_mv);
      chk("rnd_iresp_addr_ok", iresp_addr_ok, (owner == 1) && exp_aok);
      chk("rnd_iresp_data_ok", iresp_data_ok, (owner == 1) && exp_dok);
      chk("rnd_dresp_addr_ok", dresp_addr_ok, (owner == 2) && exp_aok);
      chk("rnd_dresp_data_ok", dresp_data_ok, (owner == 2) && exp_dok);
      chk("rnd_iresp_data", iresp_data, m_addr[2] ? mresp_data[63:32] : mresp_data[31:0]);
      chk("rnd_dresp_data", dresp_data, mresp_data);
      if (exp_mv) begin
        chk("rnd_mreq_addr", mreq_addr, m_addr);
        chk("rnd_mreq_size", mreq_size, m_size);
        chk("rnd_mreq_strobe", mreq_strobe, m_strb);
        chk("rnd_mreq_data", mreq_data, m_data);
      end
      if (owner == 0) begin
        if (ireq_valid || dreq_valid) begin
          fwin = ireq_valid && (!dreq_valid || starve >= LIMIT || !DPRIO);
          addr_done = 0;
          if (fwin) begin
            owner = 1; m_addr = ireq_addr; m_size = 3'd2; m_strb = '0; m_data = '0;
            starve = 0;
          end else begin
            owner = 2; m_addr = dreq_addr; m_size = dreq_size; m_strb = dreq_strobe;
            m_data = dreq_data;
            if (ireq_valid) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
          end
        end
      end else if (exp_dok) begin
        owner = 0;
      end else if (exp_aok) begin
        addr_done = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
